// File: rtl/usb_device_protocol_if.sv
// Bundle of decoder/encoder packet paths and OUT/IN endpoint signals for the USB device protocol layer.
// Pure wiring, zero latency.
// Backpressure: the encoder acknowledges a packet with pkt_sent; the OUT sink holds it off with rx_ready.
interface usb_device_protocol_if;
  logic [98:0] pkt_from_dec;
  logic        pkt_from_dec_avail;
  logic        pkt_from_dec_corrupt;
  logic [98:0] pkt_to_enc;
  logic        pkt_to_enc_avail;
  logic        pkt_sent;
  logic [63:0] rx_data;
  logic        rx_data_valid;
  logic        rx_ready;
  logic [63:0] tx_data;
  logic        tx_data_avail;
  logic        tx_data_taken;
  logic        busy;

  // Environment side: decoder, encoder and application drive the device.
  modport master (
    output pkt_from_dec, pkt_from_dec_avail, pkt_from_dec_corrupt,
    output pkt_sent, rx_ready, tx_data, tx_data_avail,
    input  pkt_to_enc, pkt_to_enc_avail, rx_data, rx_data_valid,
    input  tx_data_taken, busy
  );

  // Device protocol layer side.
  modport slave (
    input  pkt_from_dec, pkt_from_dec_avail, pkt_from_dec_corrupt,
    input  pkt_sent, rx_ready, tx_data, tx_data_avail,
    output pkt_to_enc, pkt_to_enc_avail, rx_data, rx_data_valid,
    output tx_data_taken, busy
  );
endinterface

// File: rtl/usb_device_protocol.sv
// USB device-side protocol layer: decodes tokens, ACKs/NAKs OUT data, serves IN data and awaits the host handshake.
// Latency: token pulse -> pkt_to_enc_avail one clock later; all outputs registered.
// Backpressure: a response is held on pkt_to_enc until pkt_sent; rx_ready=0 turns OUT data into a NAK.
module usb_device_protocol #(
  parameter logic [6:0] DEV_ADDR    = 7'd5,
  parameter logic [3:0] OUT_ENDP    = 4'd4,
  parameter logic [3:0] IN_ENDP     = 4'd8,
  parameter logic [7:0] TIMEOUT_LEN = 8'd255
) (
  input logic            clk,
  input logic            rst_b,
  usb_device_protocol_if.slave bus
);

  localparam logic [7:0]  SYNC     = 8'h80;
  localparam logic [7:0]  PID_OUT  = 8'hE1;
  localparam logic [7:0]  PID_IN   = 8'h69;
  localparam logic [7:0]  PID_D0   = 8'hC3;
  localparam logic [15:0] HS_ACK   = {SYNC, 8'hD2};
  localparam logic [15:0] HS_NAK   = {SYNC, 8'h5A};
  localparam logic [98:0] ACK_PKT  = {HS_ACK, 83'b0};
  localparam logic [98:0] NAK_PKT  = {HS_NAK, 83'b0};

  typedef enum logic [2:0] {
    IDLE, RX_DATA, SEND_ACK, SEND_NAK, SEND_DATA, WAIT_HS
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [98:0] pkt_to_enc_q, pkt_to_enc_d;
  logic        pkt_to_enc_avail_q, pkt_to_enc_avail_d;
  logic [63:0] rx_data_q, rx_data_d;
  logic        rx_data_valid_q, rx_data_valid_d;
  logic        tx_data_taken_q, tx_data_taken_d;
  logic        busy_q, busy_d;

  // Field views of the incoming packet.
  logic [7:0]  rx_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic [15:0] rx_hs;
  logic [63:0] rx_payload;
  logic        rx_good;
  logic        timer_expired;

  assign rx_pid        = bus.pkt_from_dec[90:83];
  assign rx_addr       = bus.pkt_from_dec[82:76];
  assign rx_endp       = bus.pkt_from_dec[75:72];
  assign rx_hs         = bus.pkt_from_dec[98:83];
  assign rx_payload    = bus.pkt_from_dec[82:19];
  assign rx_good       = bus.pkt_from_dec_avail && !bus.pkt_from_dec_corrupt;
  assign timer_expired = (timer_q == TIMEOUT_LEN);

  // Next-state and next-output computation; a packet in the expiry cycle wins over the timeout.
  always_comb begin
    state_d            = state_q;
    timer_d            = 8'd0;
    pkt_to_enc_d       = pkt_to_enc_q;
    pkt_to_enc_avail_d = pkt_to_enc_avail_q;
    rx_data_d          = rx_data_q;
    rx_data_valid_d    = 1'b0;
    tx_data_taken_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_good && rx_addr == DEV_ADDR) begin
          if (rx_pid == PID_OUT && rx_endp == OUT_ENDP) begin
            state_d = RX_DATA;
          end else if (rx_pid == PID_IN && rx_endp == IN_ENDP) begin
            pkt_to_enc_avail_d = 1'b1;
            if (bus.tx_data_avail) begin
              state_d      = SEND_DATA;
              pkt_to_enc_d = {SYNC, PID_D0, bus.tx_data, 19'b0};
            end else begin
              state_d      = SEND_NAK;
              pkt_to_enc_d = NAK_PKT;
            end
          end
        end
      end

      RX_DATA: begin
        if (bus.pkt_from_dec_avail) begin
          if (rx_good && rx_pid == PID_D0) begin
            pkt_to_enc_avail_d = 1'b1;
            if (bus.rx_ready) begin
              state_d         = SEND_ACK;
              pkt_to_enc_d    = ACK_PKT;
              rx_data_d       = rx_payload;
              rx_data_valid_d = 1'b1;
            end else begin
              state_d      = SEND_NAK;
              pkt_to_enc_d = NAK_PKT;
            end
          end else begin
            // Bad data is not answered; the host times out and retries.
            state_d = IDLE;
          end
        end else if (timer_expired) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      SEND_ACK, SEND_NAK: begin
        if (bus.pkt_sent) begin
          state_d            = IDLE;
          pkt_to_enc_d       = '0;
          pkt_to_enc_avail_d = 1'b0;
        end
      end

      SEND_DATA: begin
        if (bus.pkt_sent) begin
          state_d            = WAIT_HS;
          pkt_to_enc_d       = '0;
          pkt_to_enc_avail_d = 1'b0;
        end
      end

      WAIT_HS: begin
        if (bus.pkt_from_dec_avail) begin
          // Only a clean ACK releases the payload; anything else leaves it for the retry.
          tx_data_taken_d = rx_good && (rx_hs == HS_ACK);
          state_d         = IDLE;
        end else if (timer_expired) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: begin
        state_d            = IDLE;
        pkt_to_enc_d       = '0;
        pkt_to_enc_avail_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any transaction without pulses.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q            <= IDLE;
      timer_q            <= 8'd0;
      pkt_to_enc_q       <= '0;
      pkt_to_enc_avail_q <= 1'b0;
      rx_data_q          <= '0;
      rx_data_valid_q    <= 1'b0;
      tx_data_taken_q    <= 1'b0;
      busy_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      timer_q            <= timer_d;
      pkt_to_enc_q       <= pkt_to_enc_d;
      pkt_to_enc_avail_q <= pkt_to_enc_avail_d;
      rx_data_q          <= rx_data_d;
      rx_data_valid_q    <= rx_data_valid_d;
      tx_data_taken_q    <= tx_data_taken_d;
      busy_q             <= busy_d;
    end
  end

  assign bus.pkt_to_enc       = pkt_to_enc_q;
  assign bus.pkt_to_enc_avail = pkt_to_enc_avail_q;
  assign bus.rx_data          = rx_data_q;
  assign bus.rx_data_valid    = rx_data_valid_q;
  assign bus.tx_data_taken    = tx_data_taken_q;
  assign bus.busy             = busy_q;

endmodule

// File: doc/usb_device_protocol.md
Name: usb_device_protocol

Overview:
- Device-side (function) protocol layer of the USB link; the responder to the host-side IN/OUT transaction engine.
- Sits between the device's decoder (receive path) and encoder (transmit path), and a single OUT endpoint sink and a single IN endpoint source on the application side.
- Decodes token packets, accepts or refuses OUT data with ACK/NAK, and supplies IN data, then waits for the host's handshake.

Parameters:
DEV_ADDR, 7'd5, device address matched against token address field
OUT_ENDP, 4'd4, endpoint number that accepts OUT transactions
IN_ENDP, 4'd8, endpoint number that serves IN transactions
TIMEOUT_LEN, 8'd255, cycles to wait for a data or handshake packet before abandoning the transaction

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
pkt_from_dec  input  99  packet from decoder, valid when pkt_from_dec_avail
pkt_from_dec_avail  input  1  one-cycle pulse, new packet present
pkt_from_dec_corrupt  input  1  qualifies the avail pulse; CRC/bitstuff/EOP error
pkt_to_enc  output  99  packet to encoder
pkt_to_enc_avail  output  1  request to transmit pkt_to_enc
pkt_sent  input  1  encoder finished transmitting the current packet (one-cycle pulse)
rx_data  output  64  OUT payload to application
rx_data_valid  output  1  one-cycle pulse, rx_data written
rx_ready  input  1  application can accept an OUT payload
tx_data  input  64  IN payload from application
tx_data_avail  input  1  IN payload pending
tx_data_taken  output  1  one-cycle pulse, host ACKed tx_data; application may advance
busy  output  1  high in any state other than IDLE

Behaviour:
- Packet layout: [98:91] SYNC (`SYNC). Token: PID [90:83], addr [82:76], endp [75:72], rest 0. Data: PID [90:83], payload [82:19], [18:0]=0. Handshake: [98:83] = `HS_ACK or `HS_NAK, [82:0]=0.
- PIDs: OUT 8'hE1, IN 8'h69, DATA0 8'hC3.
- Reset: state IDLE; all outputs 0; pkt_to_enc = 0; timer 0. Reset mid-transaction aborts immediately with no pulse on rx_data_valid or tx_data_taken.
- A token matches only if it is non-corrupt, its addr equals DEV_ADDR, and its endp equals OUT_ENDP for an OUT token or IN_ENDP for an IN token.
- States and transitions:
  - IDLE:
    - Matching OUT token -> RX_DATA.
    - Matching IN token -> SEND_DATA if tx_data_avail, else SEND_NAK.
    - Corrupt, non-matching or non-token packets are ignored; stay IDLE.
  - RX_DATA: timer counts from 0.
    - Non-corrupt DATA0 with rx_ready=1: latch payload into rx_data, pulse rx_data_valid in the same cycle as the state change -> SEND_ACK.
    - Non-corrupt DATA0 with rx_ready=0 -> SEND_NAK; rx_data is unchanged.
    - Corrupt packet or any other PID -> IDLE, no response, so the host times out and retries.
    - Timer reaches TIMEOUT_LEN -> IDLE.
  - SEND_ACK / SEND_NAK:
    - pkt_to_enc_avail=1 and pkt_to_enc holds the handshake until pkt_sent.
    - pkt_sent -> IDLE; pkt_to_enc_avail drops that cycle.
  - SEND_DATA:
    - pkt_to_enc = {SYNC, DATA0, tx_data, 19'b0} with tx_data sampled on entry and held stable; pkt_to_enc_avail=1.
    - pkt_sent -> WAIT_HS.
  - WAIT_HS: timer counts from 0.
    - Non-corrupt `HS_ACK: pulse tx_data_taken -> IDLE.
    - `HS_NAK, corrupt packet, or timeout -> IDLE without tx_data_taken; data is re-offered on the host's retry.
- Timer: 8-bit. Cleared on entry to RX_DATA/WAIT_HS and held at 0 in other states. Expiry means timer == TIMEOUT_LEN. A packet arriving in the expiry cycle takes priority over timeout.
- Packets arriving in SEND_* states are dropped.
- pkt_to_enc = 0 whenever pkt_to_enc_avail = 0.
- Latency: token avail pulse -> pkt_to_enc_avail high on the next clk edge (1 cycle).

Test Plan:
- OUT token (addr 5, endp 4) then DATA0 payload 64'hDEADBEEF_01234567 with rx_ready=1 -> rx_data_valid pulse with that value, ACK packet sent, then IDLE.
- Same OUT sequence with rx_ready=0 -> NAK sent, no rx_data_valid, rx_data unchanged.
- IN token (addr 5, endp 8) with tx_data_avail=1 and tx_data=64'hA5A5_0000_FFFF_1234 -> data packet on pkt_to_enc; host ACK after pkt_sent -> single tx_data_taken pulse; repeat with host NAK -> no pulse.
- IN token with tx_data_avail=0 -> NAK sent. Token with addr 6 or corrupt flag -> no pkt_to_enc_avail, busy stays 0.
- OUT token then silence for TIMEOUT_LEN cycles -> return to IDLE with no response; the next OUT token is accepted normally. Corrupt DATA0 -> IDLE with no handshake.
- rst_b asserted in WAIT_HS -> outputs 0 asynchronously, no tx_data_taken; the next IN token restarts cleanly.
